// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds FSM encodings for the frame parser and the byte receiver.
package loader_pkg;

  localparam int         IMEM_DEPTH      = 32;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF sync, mid-bit sampling, glitch-rejecting start check.
// rx_valid pulses one cycle after the stop-bit centre; no backpressure (byte is dropped if unused).
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  logic          sync1, sync2, line_prev;
  logic [CW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick_hit;
  rx_state_t     state, state_nxt;

  always_comb begin
    tick_hit = 1'b0;
    if (state == RX_START) tick_hit = (tick == CW'(CLKS_PER_BIT / 2 - 1));
    else                   tick_hit = (tick == CW'(CLKS_PER_BIT - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (line_prev && !sync2) state_nxt = RX_START;
      // Line back high at the half-bit point means the edge was a glitch.
      RX_START: if (tick_hit) state_nxt = sync2 ? RX_IDLE : RX_BITS;
      RX_BITS:  if (tick_hit && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (tick_hit) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      state     <= RX_IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_ferr   <= 1'b0;
    end else begin
      sync1     <= uart_rx;
      sync2     <= sync1;
      line_prev <= sync2;
      state     <= state_nxt;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      if (state == RX_IDLE || tick_hit) tick <= '0;
      else                              tick <= tick + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_BITS && tick_hit) begin
        shreg   <= {sync2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == RX_STOP && tick_hit) begin
        rx_valid <= 1'b1;
        rx_data  <= shreg;
        rx_ferr  <= !sync2;
      end
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Parses A5/N/data/CHK frames from the UART and writes 32-bit words into IMEM, holding the CPU meanwhile.
// imem_we fires the cycle after each word's 4th byte; no backpressure, IMEM write port is always ready.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TIMEOUT_CLKS = 10000000,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [4:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [5:0]  words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;
  logic          rx_good, timeout_hit;
  logic [5:0]    count_n;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;
  logic [7:0]    chk;
  logic [TW-1:0] to_cnt;
  ld_state_t     state, state_nxt;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  assign rx_good     = rx_valid && !rx_ferr;
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CLKS - 1));
  assign cpu_hold    = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign load_done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_good && rx_data == HEADER_BYTE) state_nxt = COUNT;
      COUNT: begin
        if (rx_valid) begin
          if (rx_ferr || rx_data == 8'd0 || rx_data > 8'(IMEM_DEPTH)) state_nxt = ERR;
          else                                                        state_nxt = DATA;
        end else if (timeout_hit) state_nxt = ERR;
      end
      DATA: begin
        if (rx_valid) begin
          if (rx_ferr) state_nxt = ERR;
          else if (byte_idx == 2'd3 && (words_loaded + 6'd1) == count_n) state_nxt = CHECK;
        end else if (timeout_hit) state_nxt = ERR;
      end
      CHECK: begin
        if (rx_valid) state_nxt = (!rx_ferr && rx_data == chk) ? DONE : ERR;
        else if (timeout_hit) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      count_n      <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      chk          <= '0;
      to_cnt       <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (state == IDLE || rx_valid) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;

      if (state == IDLE && state_nxt == COUNT) begin
        load_error   <= 1'b0;
        words_loaded <= '0;
        chk          <= '0;
        byte_idx     <= '0;
      end
      if (state != ERR && state_nxt == ERR) load_error <= 1'b1;

      if (state == COUNT && rx_good) count_n <= rx_data[5:0];

      if (state == DATA && rx_good) begin
        chk                            <= chk ^ rx_data;
        word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
        byte_idx                       <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          imem_we      <= 1'b1;
          imem_addr    <= words_loaded[4:0];
          imem_wdata   <= {rx_data, word_buf[23:0]};
          words_loaded <= words_loaded + 6'd1;
        end
      end
    end
  end

endmodule
